// File: rtl/filter_pkg.sv
// filter_pkg: shared state encoding, default frame geometry and frame-size helpers
package filter_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam int IMG_W_DEF   = 256;
    localparam int IMG_H_DEF   = 256;
    localparam int TIMEOUT_DEF = 1024;

    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction

    // A 3x3 kernel without padding loses one pixel on every border.
    function automatic int out_count(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction
endpackage

// File: rtl/filter_frame_ctrl_raster_addr_cnt.sv
// raster_addr_cnt: loadable up-counter that saturates at its terminal count
import filter_pkg::*;

module raster_addr_cnt #(
    parameter int           W  = 16,
    parameter logic [W-1:0] TC = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc_o  = cnt_q == TC;
        cnt_d = load_i ? load_val_i : (inc_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
        cnt_o = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl: streams one frame from the source RAM into the 3x3 kernel
// and writes the kernel results to the destination RAM, with drain timeout.
import filter_pkg::*;

module filter_frame_ctrl #(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int ADDR_W  = 16,
    parameter int OUT_CNT = out_count(IMG_W, IMG_H),
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              src_rd_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [7:0]        src_data_i,
    output logic [7:0]        pix_o,
    output logic              pix_valid_o,
    input  logic [7:0]        res_i,
    input  logic              res_valid_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [7:0]        dst_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(frame_size(IMG_W, IMG_H) - 1);
    localparam logic [ADDR_W-1:0] OUT_END = ADDR_W'(OUT_CNT);

    state_e              state_q, state_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                src_rd_q, src_rd_d;
    logic                pix_valid_q;
    logic                dst_we_q, dst_we_d;
    logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
    logic [7:0]          dst_data_q, dst_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   rd_cnt, out_cnt;
    logic                rd_tc, out_tc;
    logic                accept, active, cap, fetch;

    raster_addr_cnt #(.W(ADDR_W), .TC(RD_LAST)) u_rd_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i ('0),
        .inc_i      (fetch),
        .cnt_o      (rd_cnt),
        .tc_o       (rd_tc)
    );

    raster_addr_cnt #(.W(ADDR_W), .TC(OUT_END)) u_out_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i ('0),
        .inc_i      (cap),
        .cnt_o      (out_cnt),
        .tc_o       (out_tc)
    );

    always_comb begin
        accept = state_q == ST_IDLE && start_i;
        fetch  = state_q == ST_FETCH;
        active = fetch || state_q == ST_DRAIN;
        cap    = active && res_valid_i && !out_tc;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start_i ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_d = rd_tc ? ST_DRAIN : ST_FETCH;
            // Completion wins over a coincident timeout.
            ST_DRAIN: state_d = out_tc ? ST_DONE :
                                (to_cnt_q == TO_W'(TIMEOUT - 1) && !res_valid_i) ? ST_ERR : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
        to_cnt_d   = (state_q == ST_DRAIN && !res_valid_i) ? to_cnt_q + 1'b1 : '0;
        src_rd_d   = state_d == ST_FETCH;
        busy_d     = state_d != ST_IDLE;
        done_d     = state_d == ST_DONE;
        err_d      = accept ? 1'b0 : (state_d == ST_ERR) ? 1'b1 : err_q;
        dst_we_d   = cap;
        dst_addr_d = cap ? out_cnt : '0;
        dst_data_d = cap ? res_i : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            src_rd_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            dst_we_q    <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            src_rd_q    <= src_rd_d;
            pix_valid_q <= src_rd_q;
            dst_we_q    <= dst_we_d;
            dst_addr_q  <= dst_addr_d;
            dst_data_q  <= dst_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Source RAM data arrives one cycle after the read, aligned with pix_valid_q.
    always_comb begin
        src_rd_o    = src_rd_q;
        src_addr_o  = src_rd_q ? rd_cnt : '0;
        pix_valid_o = pix_valid_q;
        pix_o       = pix_valid_q ? src_data_i : 8'd0;
        dst_we_o    = dst_we_q;
        dst_addr_o  = dst_addr_q;
        dst_data_o  = dst_data_q;
        busy_o      = busy_q;
        done_o      = done_q;
        err_o       = err_q;
    end
endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
- Frame sequencer for the 3x3 filter pipeline (data_buffer + calc).
- Reads one grey-scale frame from a source pixel RAM in raster order and streams it into the kernel's data/done inputs.
- Collects the kernel's result strobes and writes them to a destination RAM.
- Reports frame completion or timeout; sits between the image memories and the kernel instance.

Parameters:
- IMG_W, 256, frame width in pixels (>=3)
- IMG_H, 256, frame height in pixels (>=3)
- ADDR_W, 16, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- OUT_CNT, (IMG_W-2)*(IMG_H-2), number of kernel results expected per frame
- TIMEOUT, 1024, idle cycles allowed in DRAIN before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; begins a frame when idle
- src_rd_o  out  1  source RAM read strobe
- src_addr_o  out  ADDR_W  source RAM read address
- src_data_i  in  8  source RAM read data, valid 1 cycle after src_rd_o
- pix_o  out  8  pixel to kernel data_i
- pix_valid_o  out  1  pixel strobe to kernel done_i
- res_i  in  8  kernel data_o
- res_valid_i  in  1  kernel done_o
- dst_we_o  out  1  destination RAM write enable
- dst_addr_o  out  ADDR_W  destination RAM write address
- dst_data_o  out  8  destination RAM write data
- busy_o  out  1  high from accepted start until DONE/ERR exit
- done_o  out  1  one-cycle pulse on successful frame completion
- err_o  out  1  sticky timeout flag; cleared by the next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; every output 0.
- States: IDLE, FETCH, DRAIN, DONE, ERR.
- IDLE: start_i=1 -> FETCH, clears rd_cnt, out_cnt and err_o; busy_o=1 from the next cycle. start_i in any other state is ignored.
- FETCH: src_rd_o=1 every cycle with src_addr_o=rd_cnt; rd_cnt increments each cycle.
  - Cycle issuing address IMG_W*IMG_H-1 is the last FETCH cycle -> DRAIN.
  - Exactly IMG_W*IMG_H reads, back-to-back, no gaps.
- Pixel path: pix_valid_o is src_rd_o delayed one register stage; pix_o=src_data_i combinationally while pix_valid_o=1, else 0. Last pix_valid_o occurs in the first DRAIN cycle.
- Result capture, active in FETCH and DRAIN only: res_valid_i=1 and out_cnt<OUT_CNT -> next cycle dst_we_o=1, dst_addr_o=out_cnt, dst_data_o=res_i; out_cnt increments. Write latency is 1 cycle.
  - Results when out_cnt==OUT_CNT, or in IDLE/DONE/ERR, are dropped (no write).
- DRAIN: to_cnt increments each cycle, clears on res_valid_i.
  - out_cnt reaches OUT_CNT -> DONE. This takes priority over timeout in the same cycle.
  - to_cnt==TIMEOUT-1 with no result -> ERR.
- DONE: one cycle; done_o=1, busy_o drops the following cycle; -> IDLE.
- ERR: one cycle; err_o set (held until the next start), done_o stays 0; -> IDLE.
- Reset mid-frame: immediate return to IDLE, outputs 0; in-flight kernel results are discarded. The kernel shares rst and flushes with it.
- Counters: rd_cnt and out_cnt are ADDR_W bits and never wrap within a frame.

Decomposition:
- filter_pkg holds:
  - the state enum encoding (3 bits);
  - default IMG_W/IMG_H;
  - a frame-size constant function (W*H) and an out-count constant function ((W-2)*(H-2)).
- One sub-module is natural: raster_addr_cnt, a loadable counter with a terminal-count flag. It is instantiated twice, once for rd_cnt and once for out_cnt; the timeout counter stays inline.

Test Plan:
- Nominal, IMG_W=IMG_H=4, OUT_CNT=4: start pulse -> 16 consecutive reads at addresses 0..15; pix_valid_o high 16 cycles, lagging src_rd_o by 1; 4 results written to dst 0..3; done_o pulses once; err_o=0.
- Timeout, TIMEOUT=8: kernel model emits only 3 results -> ERR 8 cycles after the last result; err_o=1, no done_o, busy_o=0. A new start clears err_o.
- Surplus results: model emits 6 strobes -> only 4 writes (addresses 0..3); strobes 5 and 6 are dropped; done_o is asserted once.
- Start while busy: second start_i at read 5 -> ignored; read sequence is uninterrupted and the frame completes normally.
- Async reset at FETCH address 7: all outputs 0 within the reset cycle, with no clock edge needed. A subsequent start restarts reads at address 0.
- Result on the final DRAIN timeout cycle: res_valid_i arrives at to_cnt=TIMEOUT-1 -> to_cnt clears, no ERR; a result completing OUT_CNT goes to DONE.
